// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and FSM encodings for the register-bank write scheduler
package regfile_pkg;

   localparam int RF_ADDR_W   = 5;
   localparam int RF_DATA_W   = 32;
   localparam int RF_NUM_REGS = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational one-hot arbiter; RR_ARB_EN selects round-robin, else fixed priority
module rr_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
`ifdef RR_ARB_EN
   input  logic [PTR_W-1:0]   ptr,
`endif
   output logic [NUM_REQ-1:0] gnt
);

`ifdef RR_ARB_EN
   // Walk the search order backwards so the candidate closest to ptr is written last and wins.
   always_comb begin
      gnt = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % NUM_REQ]) begin
            gnt = NUM_REQ'(1) << ((int'(ptr) + k) % NUM_REQ);
         end
      end
   end
`else
   always_comb begin
      gnt = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[k]) begin
            gnt = NUM_REQ'(1) << k;
         end
      end
   end
`endif

endmodule

// File: rtl/regfile_wr_sched.sv
// rtl/regfile_wr_sched.sv - write-port scheduler and bank-clear sequencer; RR_ARB_EN enables round-robin
module regfile_wr_sched
   import regfile_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int NUM_REGS = RF_NUM_REGS,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int DATA_W   = RF_DATA_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   input  logic                      clr_start,
   output logic                      clr_busy,
   output logic                      clr_done,
   input  logic                      rf_stall,
   output logic                      rf_we,
   output logic [ADDR_W-1:0]         rf_waddr,
   output logic [DATA_W-1:0]         rf_wdata
);

   localparam int                PTR_W     = $clog2(NUM_REQ);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   clr_cnt;
   logic [NUM_REQ-1:0]  arb_gnt;
   logic [ADDR_W-1:0]   win_addr;
   logic [DATA_W-1:0]   win_data;

`ifdef RR_ARB_EN
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] win_idx;

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) win_idx = PTR_W'(i);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (|gnt) begin
         ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
      .req (req),
      .ptr (ptr),
      .gnt (arb_gnt)
   );
`else
   rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
      .req (req),
      .gnt (arb_gnt)
   );
`endif

   always_comb begin
      win_addr = '0;
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            win_addr = req_addr[i*ADDR_W +: ADDR_W];
            win_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (!rf_stall && clr_start) state_nxt = ST_CLEAR;
         ST_CLEAR: if (!rf_stall && clr_cnt == LAST_ADDR) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      gnt      = '0;
      clr_busy = 1'b0;
      clr_done = 1'b0;
      case (state)
         ST_IDLE:  if (!rf_stall && !clr_start) gnt = arb_gnt;
         ST_CLEAR: clr_busy = 1'b1;
         ST_DONE: begin
            clr_busy = 1'b1;
            clr_done = 1'b1;
         end
         default: ;
      endcase
   end

   // During CLEAR rf_waddr always mirrors clr_cnt; a stall freezes both along with rf_we.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         clr_cnt  <= '0;
      end else if (!rf_stall) begin
         case (state)
            ST_IDLE: begin
               if (clr_start) begin
                  rf_we    <= 1'b1;
                  rf_waddr <= '0;
                  rf_wdata <= '0;
                  clr_cnt  <= '0;
               end else if (|gnt) begin
                  rf_we    <= 1'b1;
                  rf_waddr <= win_addr;
                  rf_wdata <= win_data;
               end else begin
                  rf_we    <= 1'b0;
               end
            end
            ST_CLEAR: begin
               if (clr_cnt == LAST_ADDR) begin
                  rf_we   <= 1'b0;
                  clr_cnt <= '0;
               end else begin
                  clr_cnt  <= clr_cnt + 1'b1;
                  rf_waddr <= clr_cnt + 1'b1;
               end
            end
            default: rf_we <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// tb/tb_regfile_wr_sched.sv - scoreboard bench for regfile_wr_sched (default or RR_ARB_EN build)
module tb_regfile_wr_sched;

   localparam int NR = 4;
   localparam int AW = 5;
   localparam int DW = 32;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [NR-1:0]  req = '0;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic [NR-1:0]  gnt;
   logic           clr_start = 1'b0;
   logic           clr_busy;
   logic           clr_done;
   logic           rf_stall = 1'b0;
   logic           rf_we;
   logic [AW-1:0]  rf_waddr;
   logic [DW-1:0]  rf_wdata;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  n_cmp = 0;
   int  n_bad = 0;

   regfile_wr_sched #(.NUM_REQ(NR), .NUM_REGS(32), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .gnt       (gnt),
      .clr_start (clr_start),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done),
      .rf_stall  (rf_stall),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[i] = 1'b1;
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   // Monitor: every write the bank accepts must match the next scoreboard entry.
   always @(negedge clk) begin
      if (reset === 1'b0 && rf_we === 1'b1 && rf_stall === 1'b0) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", rf_waddr, rf_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 64'(rf_waddr), 64'(mon_e.a));
            check("wr_data", 64'(rf_wdata), 64'(mon_e.d));
         end
      end
   end

   task automatic run_clear(input string tag);
      int busy = 0;
      int done = 0;
      bit ended = 0;
      for (int c = 0; c < 100; c++) begin
         #1;
         if (!clr_busy) begin
            ended = 1;
            break;
         end
         busy++;
         if (clr_done) done++;
         check({tag, "_gnt_blocked"}, 64'(gnt), 64'(0));
         tick();
      end
      check({tag, "_ended"}, 64'(ended), 64'(1));
      check({tag, "_busy_cycles"}, 64'(busy), 64'(33));
      check({tag, "_done_pulses"}, 64'(done), 64'(1));
   endtask

   initial begin
      int win;
      int done;
      bit found;

      // Reset state
      tick();
      tick();
      #1;
      check("rst_we", 64'(rf_we), 64'(0));
      check("rst_waddr", 64'(rf_waddr), 64'(0));
      check("rst_wdata", 64'(rf_wdata), 64'(0));
      check("rst_busy", 64'(clr_busy), 64'(0));
      check("rst_done", 64'(clr_done), 64'(0));
      check("rst_gnt", 64'(gnt), 64'(0));
      reset = 1'b0;
      tick();
      #1;
      check("idle_we0", 64'(rf_we), 64'(0));
      tick();
      #1;
      check("idle_we1", 64'(rf_we), 64'(0));

      // Single writer
      tick();
      set_req(2, 5'd7, 32'hDEADBEEF);
      #1;
      check("single_gnt", 64'(gnt), 64'(4'b0100));
      push(5'd7, 32'hDEADBEEF);
      tick();
      req = '0;
      #1;
      check("single_we", 64'(rf_we), 64'(1));

      // Asynchronous reset mid-cycle while a write is presented
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("async_we", 64'(rf_we), 64'(0));
      check("async_waddr", 64'(rf_waddr), 64'(0));
      check("async_wdata", 64'(rf_wdata), 64'(0));
      tick();
      tick();
      reset = 1'b0;
      tick();
      #1;
      check("post_rst_we", 64'(rf_we), 64'(0));

      // Contention: all four requesters held
      tick();
      for (int i = 0; i < NR; i++) set_req(i, AW'(i + 1), 32'h100 + i);
      for (int c = 0; c < 5; c++) begin
         #1;
`ifdef RR_ARB_EN
         win = c % NR;
`else
         win = 0;
`endif
         check("contend_gnt", 64'(gnt), 64'(1) << win);
         push(AW'(win + 1), 32'h100 + win);
         tick();
      end
      req = '0;
      tick();

      // Stall holds the presented write for three cycles
      set_req(1, 5'd9, 32'hCAFE0001);
      #1;
      check("stall_pre_gnt", 64'(gnt), 64'(4'b0010));
      push(5'd9, 32'hCAFE0001);
      tick();
      req = '0;
      rf_stall = 1'b1;
      set_req(3, 5'd17, 32'h0BADF00D);
      for (int s = 0; s < 3; s++) begin
         #1;
         check("stall_gnt", 64'(gnt), 64'(0));
         check("stall_we", 64'(rf_we), 64'(1));
         check("stall_waddr", 64'(rf_waddr), 64'(9));
         check("stall_wdata", 64'(rf_wdata), 64'(32'hCAFE0001));
         tick();
      end
      rf_stall = 1'b0;
      #1;
      check("unstall_gnt", 64'(gnt), 64'(4'b1000));
      push(5'd17, 32'h0BADF00D);
      tick();
      req = '0;
      tick();
      tick();

      // Full clear with requesters 0 and 1 pending
      set_req(0, 5'd3, 32'h11111111);
      set_req(1, 5'd4, 32'h22222222);
      clr_start = 1'b1;
      #1;
      check("clr_prio_gnt", 64'(gnt), 64'(0));
      for (int a = 0; a < 32; a++) push(AW'(a), 32'h0);
      tick();
      clr_start = 1'b0;
      run_clear("clr1");
      check("resume_gnt", 64'(gnt), 64'(4'b0001));
      push(5'd3, 32'h11111111);
      tick();
      req = '0;
      tick();
      tick();

      // Reset part-way through a clear, then restart
      clr_start = 1'b1;
      for (int a = 0; a < 12; a++) push(AW'(a), 32'h0);
      tick();
      clr_start = 1'b0;
      done = 0;
      found = 0;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (clr_done) done++;
         if (clr_busy && rf_waddr == 5'd12) begin
            found = 1;
            break;
         end
         tick();
      end
      check("abort_reached12", 64'(found), 64'(1));
      reset = 1'b1;
      #1;
      check("abort_busy", 64'(clr_busy), 64'(0));
      check("abort_we", 64'(rf_we), 64'(0));
      tick();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (clr_done) done++;
         check("abort_idle_busy", 64'(clr_busy), 64'(0));
         tick();
      end
      check("abort_no_done", 64'(done), 64'(0));
      clr_start = 1'b1;
      for (int a = 0; a < 32; a++) push(AW'(a), 32'h0);
      tick();
      clr_start = 1'b0;
      run_clear("clr2");
      tick();
      tick();

      check("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      n_bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
